iomem_gpio: RTL and testbench

//  Parametrised GPIO peripheral on the rvsoc iomem bus; successor to the fixed 32-bit scratch GPIO register.

---
 rtl/iomem_gpio.sv | 157 +++++++++++++++
 tb/tb_iomem_gpio.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_gpio.sv
// GPIO peripheral on the rvsoc iomem bus: direction, atomic set/clear/toggle,
// synchronised inputs and sticky edge-detect interrupts.
module iomem_gpio #(
   parameter int unsigned NUM_PINS    = 32,
   parameter logic [7:0]  BASE_ADDR   = 8'h03,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                iomem_valid,
   output logic                iomem_ready,
   input  logic [3:0]          iomem_wstrb,
   input  logic [31:0]         iomem_addr,
   input  logic [31:0]         iomem_wdata,
   output logic [31:0]         iomem_rdata,
   input  logic [NUM_PINS-1:0] gpio_in,
   output logic [NUM_PINS-1:0] gpio_out,
   output logic [NUM_PINS-1:0] gpio_oe,
   output logic                irq
);

   typedef logic [NUM_PINS-1:0] pins_t;

   localparam logic [5:0] RegDataOut = 6'h00;
   localparam logic [5:0] RegDir     = 6'h01;
   localparam logic [5:0] RegDataIn  = 6'h02;
   localparam logic [5:0] RegOutSet  = 6'h03;
   localparam logic [5:0] RegOutClr  = 6'h04;
   localparam logic [5:0] RegOutTgl  = 6'h05;
   localparam logic [5:0] RegRiseEn  = 6'h06;
   localparam logic [5:0] RegFallEn  = 6'h07;
   localparam logic [5:0] RegPend    = 6'h08;

   pins_t data_out_q, data_out_d;
   pins_t dir_q, dir_d;
   pins_t rise_en_q, rise_en_d;
   pins_t fall_en_q, fall_en_d;
   pins_t pend_q, pend_d;
   pins_t prev_in_q, prev_in_d;
   pins_t sync_q [SYNC_STAGES];
   pins_t sync_d [SYNC_STAGES];
   logic        ready_q, ready_d;
   logic [31:0] rdata_q, rdata_d;

   logic        accept;
   logic        wr_en;
   logic [5:0]  reg_sel;
   logic [31:0] byte_m;
   logic [31:0] wdata_m;
   logic [31:0] rd_val;
   pins_t       wmask;
   pins_t       wbits;
   pins_t       data_in;
   pins_t       events;
   logic        unused_addr;

   assign unused_addr = ^{iomem_addr[23:8], iomem_addr[1:0]};

   assign reg_sel = iomem_addr[7:2];
   assign accept  = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE_ADDR);
   assign wr_en   = accept && (iomem_wstrb != 4'b0000);

   assign byte_m  = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                     {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
   assign wdata_m = iomem_wdata & byte_m;
   assign wmask   = byte_m[NUM_PINS-1:0];
   assign wbits   = wdata_m[NUM_PINS-1:0];

   assign data_in = sync_q[SYNC_STAGES-1];
   // Edge detect looks at the synchronised pins regardless of direction.
   assign events  = (data_in & ~prev_in_q & rise_en_q) | (~data_in & prev_in_q & fall_en_q);

   always_comb begin
      rd_val = 32'h0;
      case (reg_sel)
         RegDataOut: rd_val = 32'(data_out_q);
         RegDir:     rd_val = 32'(dir_q);
         RegDataIn:  rd_val = 32'(data_in);
         RegRiseEn:  rd_val = 32'(rise_en_q);
         RegFallEn:  rd_val = 32'(fall_en_q);
         RegPend:    rd_val = 32'(pend_q);
         default:    rd_val = 32'h0;
      endcase
   end

   always_comb begin
      data_out_d = data_out_q;
      dir_d      = dir_q;
      rise_en_d  = rise_en_q;
      fall_en_d  = fall_en_q;
      pend_d     = pend_q;
      rdata_d    = rdata_q;
      ready_d    = accept;
      prev_in_d  = data_in;

      sync_d[0] = gpio_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end

      if (accept) begin
         rdata_d = rd_val;
      end

      if (wr_en) begin
         case (reg_sel)
            RegDataOut: data_out_d = (data_out_q & ~wmask) | wbits;
            RegDir:     dir_d      = (dir_q & ~wmask) | wbits;
            RegOutSet:  data_out_d = data_out_q | wbits;
            RegOutClr:  data_out_d = data_out_q & ~wbits;
            RegOutTgl:  data_out_d = data_out_q ^ wbits;
            RegRiseEn:  rise_en_d  = (rise_en_q & ~wmask) | wbits;
            RegFallEn:  fall_en_d  = (fall_en_q & ~wmask) | wbits;
            RegPend:    pend_d     = pend_q & ~wbits;
            default:    ;
         endcase
      end

      // A new qualifying edge wins over a same-cycle clear.
      pend_d = pend_d | events;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         data_out_q <= '0;
         dir_q      <= '0;
         rise_en_q  <= '0;
         fall_en_q  <= '0;
         pend_q     <= '0;
         prev_in_q  <= '0;
         ready_q    <= 1'b0;
         rdata_q    <= 32'h0;
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         data_out_q <= data_out_d;
         dir_q      <= dir_d;
         rise_en_q  <= rise_en_d;
         fall_en_q  <= fall_en_d;
         pend_q     <= pend_d;
         prev_in_q  <= prev_in_d;
         ready_q    <= ready_d;
         rdata_q    <= rdata_d;
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
      end
   end

   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;
   assign gpio_out    = data_out_q;
   assign gpio_oe     = dir_q;
   assign irq         = |pend_q;

endmodule

// File: tb/tb_iomem_gpio.sv
// Bench for iomem_gpio: directed vector table, hand sequences for timing corners,
// and randomized traffic against a register-level reference model.
module tb_iomem_gpio;

   localparam int S0 = 2;
   localparam logic [31:0] BASE = 32'h0300_0000;

   logic        clk = 1'b0;
   logic        resetn;
   logic        tgt;
   logic        valid;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] gpio_in;

   logic        valid0, valid1, rdy0, rdy1, irq0, irq8, rdy;
   logic [31:0] rd0, rd1, rd_mux;
   logic [31:0] out0, oe0;
   logic [7:0]  out8, oe8;

   int checks   = 0;
   int failures = 0;

   assign valid0 = valid & ~tgt;
   assign valid1 = valid & tgt;
   assign rdy    = tgt ? rdy1 : rdy0;
   assign rd_mux = tgt ? rd1 : rd0;

   always #5 clk = ~clk;

   iomem_gpio #(.NUM_PINS(32), .BASE_ADDR(8'h03), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .iomem_valid (valid0),
      .iomem_ready (rdy0),
      .iomem_wstrb (wstrb),
      .iomem_addr  (addr),
      .iomem_wdata (wdata),
      .iomem_rdata (rd0),
      .gpio_in     (gpio_in),
      .gpio_out    (out0),
      .gpio_oe     (oe0),
      .irq         (irq0)
   );

   iomem_gpio #(.NUM_PINS(8), .BASE_ADDR(8'h03), .SYNC_STAGES(3)) dut8 (
      .clk         (clk),
      .resetn      (resetn),
      .iomem_valid (valid1),
      .iomem_ready (rdy1),
      .iomem_wstrb (wstrb),
      .iomem_addr  (addr),
      .iomem_wdata (wdata),
      .iomem_rdata (rd1),
      .gpio_in     (gpio_in[7:0]),
      .gpio_out    (out8),
      .gpio_oe     (oe8),
      .irq         (irq8)
   );

   // Reference model of the 32-pin instance: register contents plus a history of sampled pins.
   logic [31:0] m_out = '0, m_dir = '0, m_rise = '0, m_fall = '0, m_pend = '0, m_rdata = '0;
   logic        m_ready = 1'b0;
   logic [31:0] hist [S0+1];

   always @(posedge clk) begin : model
      logic [31:0] din, prv, ev, bm, d, rv;
      logic        acc, wr;
      logic [5:0]  off;
      if (!resetn) begin
         m_out <= '0; m_dir <= '0; m_rise <= '0; m_fall <= '0; m_pend <= '0;
         m_rdata <= '0; m_ready <= 1'b0;
         for (int i = 0; i <= S0; i++) hist[i] <= '0;
      end else begin
         din = hist[S0-1];
         prv = hist[S0];
         ev  = (din & ~prv & m_rise) | (~din & prv & m_fall);
         acc = valid0 && !m_ready && (addr[31:24] == 8'h03);
         bm  = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
         d   = wdata & bm;
         wr  = acc && (wstrb != 4'b0);
         off = addr[7:2];
         case (off)
            6'd0: rv = m_out;
            6'd1: rv = m_dir;
            6'd2: rv = din;
            6'd6: rv = m_rise;
            6'd7: rv = m_fall;
            6'd8: rv = m_pend;
            default: rv = 32'h0;
         endcase
         if (acc) m_rdata <= rv;
         m_ready <= acc;
         if (wr) begin
            case (off)
               6'd0: m_out  <= (m_out & ~bm) | d;
               6'd1: m_dir  <= (m_dir & ~bm) | d;
               6'd3: m_out  <= m_out | d;
               6'd4: m_out  <= m_out & ~d;
               6'd5: m_out  <= m_out ^ d;
               6'd6: m_rise <= (m_rise & ~bm) | d;
               6'd7: m_fall <= (m_fall & ~bm) | d;
               default: ;
            endcase
         end
         m_pend <= (m_pend & ~((wr && off == 6'd8) ? d : 32'h0)) | ev;
         hist[0] <= gpio_in;
         for (int i = 1; i <= S0; i++) hist[i] <= hist[i-1];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Starts and ends just after a negedge; request accepted at the next posedge.
   task automatic access(input logic t, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] dv, output logic [31:0] rd);
      tgt = t; addr = a; wstrb = s; wdata = dv; valid = 1'b1;
      @(posedge clk); @(negedge clk);
      check("ready_high", {31'h0, rdy}, 32'h1);
      rd = rd_mux;
      valid = 1'b0;
      @(posedge clk); @(negedge clk);
      check("ready_low", {31'h0, rdy}, 32'h0);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [3:0]  s;
      logic [31:0] d;
      logic [31:0] exp_rd;
      logic [31:0] exp_out;
   } vec_t;

   vec_t vecs[14];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rd;
      resetn = 1'b0; tgt = 1'b0; valid = 1'b1; addr = BASE; wstrb = 4'h0; wdata = '0;
      gpio_in = '0;

      // Reset with a request pending.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", {31'h0, rdy0}, 32'h0);
      check("rst_out", out0, 32'h0);
      check("rst_oe", oe0, 32'h0);
      check("rst_irq", {31'h0, irq0}, 32'h0);
      check("rst_rdata", rd0, 32'h0);
      check("rst_out8", {24'h0, out8}, 32'h0);
      valid = 1'b0; resetn = 1'b1;
      @(negedge clk);

      vecs[0]  = '{BASE | 32'h00, 4'h1, 32'h0000_00A5, 32'h0, 32'h0000_00A5};
      vecs[1]  = '{BASE | 32'h0C, 4'hF, 32'h0000_0100, 32'h0, 32'h0000_01A5};
      vecs[2]  = '{BASE | 32'h10, 4'hF, 32'h0000_0001, 32'h0, 32'h0000_01A4};
      vecs[3]  = '{BASE | 32'h14, 4'hF, 32'h0000_00FF, 32'h0, 32'h0000_015B};
      vecs[4]  = '{BASE | 32'h00, 4'h0, 32'h0, 32'h0000_015B, 32'h0000_015B};
      vecs[5]  = '{BASE | 32'h0C, 4'h0, 32'h0, 32'h0, 32'h0000_015B};
      vecs[6]  = '{BASE | 32'h04, 4'h2, 32'hFFFF_FFFF, 32'h0, 32'h0000_015B};
      vecs[7]  = '{BASE | 32'h04, 4'h0, 32'h0, 32'h0000_FF00, 32'h0000_015B};
      vecs[8]  = '{BASE | 32'h00, 4'hC, 32'h1234_5678, 32'h0000_015B, 32'h1234_015B};
      vecs[9]  = '{BASE | 32'h00, 4'h0, 32'h0, 32'h1234_015B, 32'h1234_015B};
      vecs[10] = '{BASE | 32'h28, 4'hF, 32'hFFFF_FFFF, 32'h0, 32'h1234_015B};
      vecs[11] = '{BASE | 32'h28, 4'h0, 32'h0, 32'h0, 32'h1234_015B};
      vecs[12] = '{BASE | 32'h08, 4'h0, 32'h0, 32'h0, 32'h1234_015B};
      vecs[13] = '{BASE | 32'h0012_3410, 4'h1, 32'hFFFF_FFFF, 32'h0, 32'h1234_0100};
      for (int i = 0; i < 14; i++) begin
         access(1'b0, vecs[i].a, vecs[i].s, vecs[i].d, rd);
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
         check($sformatf("vec%0d_out", i), out0, vecs[i].exp_out);
      end

      // Rise on pin 0 and fall on pin 1 in the same cycle.
      gpio_in = 32'h2;
      repeat (4) @(negedge clk);
      access(1'b0, BASE | 32'h18, 4'hF, 32'h1, rd);
      access(1'b0, BASE | 32'h1C, 4'hF, 32'h2, rd);
      check("irq_idle", {31'h0, irq0}, 32'h0);
      gpio_in = 32'h1;
      @(negedge clk); @(negedge clk);
      check("irq_early", {31'h0, irq0}, 32'h0);
      @(negedge clk);
      check("irq_set", {31'h0, irq0}, 32'h1);
      access(1'b0, BASE | 32'h20, 4'h0, 32'h0, rd);
      check("pend_both", rd, 32'h3);
      access(1'b0, BASE | 32'h20, 4'hF, 32'h1, rd);
      check("irq_after_w1c0", {31'h0, irq0}, 32'h1);
      access(1'b0, BASE | 32'h20, 4'h0, 32'h0, rd);
      check("pend_bit1", rd, 32'h2);
      access(1'b0, BASE | 32'h20, 4'hF, 32'h2, rd);
      check("irq_cleared", {31'h0, irq0}, 32'h0);

      // Clear of PEND[0] coincides with a fresh qualifying rise.
      gpio_in = 32'h0;
      repeat (4) @(negedge clk);
      gpio_in = 32'h1;
      repeat (4) @(negedge clk);
      check("pend0_armed", {31'h0, irq0}, 32'h1);
      gpio_in = 32'h0;
      repeat (4) @(negedge clk);
      gpio_in = 32'h1;
      @(negedge clk); @(negedge clk);
      access(1'b0, BASE | 32'h20, 4'hF, 32'h1, rd);
      check("pend_race_old", rd, 32'h1);
      access(1'b0, BASE | 32'h20, 4'h0, 32'h0, rd);
      check("pend_race_set_wins", rd, 32'h1);
      access(1'b0, BASE | 32'h20, 4'hF, 32'h1, rd);
      access(1'b0, BASE | 32'h20, 4'h0, 32'h0, rd);
      check("pend_plain_clear", rd, 32'h0);

      // Narrow instance: upper bits dropped, wrong base ignored, 3-stage sync latency.
      access(1'b1, BASE | 32'h04, 4'hF, 32'hFFFF_FFFF, rd);
      access(1'b1, BASE | 32'h04, 4'h0, 32'h0, rd);
      check("n8_dir_read", rd, 32'h0000_00FF);
      check("n8_oe", {24'h0, oe8}, 32'h0000_00FF);
      access(1'b1, BASE | 32'h00, 4'hF, 32'hABCD_1234, rd);
      access(1'b1, BASE | 32'h00, 4'h0, 32'h0, rd);
      check("n8_out_read", rd, 32'h0000_0034);
      tgt = 1'b1; addr = 32'h0400_0004; wstrb = 4'hF; wdata = 32'h0; valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); @(negedge clk);
         check($sformatf("n8_nomatch_%0d", i), {31'h0, rdy1}, 32'h0);
      end
      valid = 1'b0;
      access(1'b1, BASE | 32'h04, 4'h0, 32'h0, rd);
      check("n8_dir_kept", rd, 32'h0000_00FF);
      access(1'b1, BASE | 32'h18, 4'hF, 32'hFFFF_FFFF, rd);
      access(1'b1, BASE | 32'h18, 4'h0, 32'h0, rd);
      check("n8_rise_read", rd, 32'h0000_00FF);
      check("n8_irq_idle", {31'h0, irq8}, 32'h0);
      gpio_in = 32'h81;
      repeat (3) @(negedge clk);
      check("n8_irq_early", {31'h0, irq8}, 32'h0);
      @(negedge clk);
      check("n8_irq_set", {31'h0, irq8}, 32'h1);

      // Reset in the ready cycle of an accepted write.
      tgt = 1'b0; addr = BASE | 32'h04; wstrb = 4'hF; wdata = 32'h0000_FFFF; valid = 1'b1;
      @(posedge clk); @(negedge clk);
      check("mid_ready", {31'h0, rdy0}, 32'h1);
      resetn = 1'b0; valid = 1'b0;
      @(posedge clk); @(negedge clk);
      check("mid_rst_ready", {31'h0, rdy0}, 32'h0);
      check("mid_rst_out", out0, 32'h0);
      check("mid_rst_oe", oe0, 32'h0);
      check("mid_rst_irq8", {31'h0, irq8}, 32'h0);
      check("mid_rst_rdata", rd0, 32'h0);
      resetn = 1'b1;
      @(negedge clk);
      foreach (vecs[i]) begin
         if (i < 5) begin
            logic [31:0] offs [5];
            offs = '{32'h00, 32'h04, 32'h18, 32'h1C, 32'h20};
            access(1'b0, BASE | offs[i], 4'h0, 32'h0, rd);
            check($sformatf("post_rst_reg%0d", i), rd, 32'h0);
         end
      end

      // Randomized traffic against the model.
      tgt = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         check("rnd_ready_irq", {30'h0, rdy0, irq0}, {30'h0, m_ready, |m_pend});
         check("rnd_rdata", rd0, m_rdata);
         check("rnd_out", out0, m_out);
         check("rnd_oe", oe0, m_dir);
         resetn = ($urandom_range(0, 399) != 0);
         valid  = ($urandom_range(0, 3) != 0);
         addr   = {(($urandom_range(0, 9) == 0) ? 8'h07 : 8'h03), 16'($urandom),
                   6'($urandom_range(0, 12)), 2'b00};
         wstrb  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         wdata  = $urandom;
         if ($urandom_range(0, 2) == 0) gpio_in = gpio_in ^ (32'h1 << $urandom_range(0, 31));
      end
      @(negedge clk);
      check("rnd_final_out", out0, m_out);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
